fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer that owns the program counter and drives the select of the next-PC multiplexer. It issues one instruction-memory request at a time and returns fetched words through a one-entry buffer to decode. It also applies branch/jump redirects from execute, discarding any fetch that is in flight when a redirect arrives. It sits between the PC register, the next-PC mux (`npc_sel` out, `npc` back in) and the instruction memory port.

## Interface
- RESET_PC, default 32'h0000_0000, PC value loaded on reset.
- clk  in  1  single clock; all state updates on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- npc  in  32  next PC returned by the next-PC mux; equals pc+4 when `npc_sel`=00 and the branch/jump offset target when `npc_sel`=01.
- npc_sel  out  2  mux select: 00 sequential, 01 offset; 10/11 never driven.
- pc  out  32  current PC register.
- redirect_valid  in  1  one-cycle pulse from execute: branch/jump taken this cycle.
- stall  in  1  decode cannot accept the buffered instruction.
- imem_req_valid  out  1  fetch request.
- imem_req_addr  out  32  fetch address; always equals `pc`.
- imem_req_ready  in  1  memory accepts the request.
- imem_rsp_valid  in  1  read data valid.
- imem_rsp_data  in  32  fetched word.
- inst_valid  out  1  buffer holds a valid instruction.
- inst  out  32  buffered instruction.
- inst_pc  out  32  address of the buffered instruction.

## Operation
- States: IDLE, REQ, WAIT. A `drop` flag marks the in-flight response as stale.
- IDLE: entered on reset. Moves to REQ on the next edge unconditionally.
- REQ: `imem_req_valid` = !inst_valid || !stall. A handshake (req_valid && ready) moves to WAIT.
- WAIT: waits for `imem_rsp_valid`.
  - If `drop`=1: discard the data, clear `drop`, go to REQ.
  - Otherwise: load inst<=rsp_data, inst_pc<=pc, inst_valid<=1; pc<=npc with npc_sel=00; go to REQ.
- `imem_rsp_valid` in IDLE or REQ is ignored.
- Buffer consume: inst_valid && !stall clears inst_valid next edge. The buffer is empty whenever the FSM is in WAIT, so a load and a consume never collide.
- `npc_sel` = 01 when redirect_valid=1, else 00.
- `pc` loads only on a redirect or on a non-dropped response.
- Redirect, in any state:
  - pc<=npc (the offset target) and inst_valid<=0.
  - If the FSM is in WAIT, or a handshake completes this cycle, drop<=1.
  - A redirect in the same cycle as a response: the response is dropped, pc takes the redirect target, and the state goes to REQ.
  - A redirect in IDLE updates pc; the FSM still moves to REQ.
- Only one request is ever outstanding. The memory must return exactly one response per accepted request.

## Timing
- Reset values, applied asynchronously while rstn=0:
  - state=IDLE, pc=RESET_PC, drop=0.
  - inst_valid=0, inst=0, inst_pc=0.
  - imem_req_valid=0, npc_sel=00.
- After rstn rises: edge 1 moves IDLE→REQ. `imem_req_valid`=1 with addr=RESET_PC in the following cycle.
- With a 1-cycle memory (req accepted at cycle t, rsp at t+1) and stall=0:
  - inst_valid is asserted in t+2.
  - The next request also issues in t+2.
  - Throughput is one instruction every 2 cycles.
- `imem_req_valid` may drop while waiting for ready only because stall rises; `imem_req_addr` is stable while valid is held.
- Redirect latency: the first request to the target issues in the cycle after the redirect, or after the stale response returns when drop=1.
- `npc_sel` is combinational from `redirect_valid`. `npc` must be valid in the same cycle.

## Test plan
- Reset, RESET_PC=32'h100: hold rstn=0 → pc=32'h100, imem_req_valid=0, inst_valid=0, npc_sel=00. Release → req issued 2nd cycle with addr 32'h100.
- Sequential fetch, 1-cycle memory returning addr^32'hA5A5_0000, mux model npc=pc+4 → inst_pc sequence 100,104,108 with matching inst. Each inst_valid is followed by a req in the same cycle.
- Stall: hold stall=1 for 3 cycles while inst_valid=1 → inst and inst_pc stable, imem_req_valid=0. Release → buffer consumed and next req issues that cycle.
- Redirect in WAIT: redirect_valid with npc=32'h200 while a response is pending, memory latency 3 → stale rsp never appears on inst. Next req addr=32'h200, then inst_pc=32'h200.
- Redirect coincident with imem_rsp_valid → response dropped, inst_valid stays 0, pc=target, npc_sel=01 in that cycle only.
- rstn pulsed low in WAIT → all outputs return to reset values immediately. A late imem_rsp_valid arriving during IDLE/REQ is ignored.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Owns the program counter and steers the external next-PC mux. It keeps
// at most one instruction-memory request outstanding. Fetched words go to
// decode through a one-entry buffer. Branch/jump redirects from execute
// reload the PC and mark any in-flight fetch as stale.
//
// Ports
//   clk            : clock, all state changes on the rising edge
//   rstn           : asynchronous active-low reset
//   npc            : next PC from the mux (pc+4 or redirect target)
//   npc_sel        : mux select, 2'b00 sequential, 2'b01 offset target
//   pc             : current program counter
//   redirect_valid : one-cycle taken branch/jump pulse from execute
//   stall          : decode cannot accept the buffered instruction
//   imem_req_*     : fetch request channel (address always equals pc)
//   imem_rsp_*     : fetch response channel, one response per request
//   inst_valid     : buffer holds an instruction for decode
//   inst, inst_pc  : buffered instruction word and its address
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] npc,
  output logic [1:0]  npc_sel,
  output logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic        stall,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } state_t;

  state_t      state_r;
  logic        drop_r;
  logic [31:0] pc_r;
  logic        inst_valid_r;
  logic [31:0] inst_r;
  logic [31:0] inst_pc_r;
  logic        req_valid_s;
  logic        hs_s;

  // Request qualification: a fetch is offered only when the buffer slot
  // is free now or will be freed by decode at this edge.
  always_comb begin
    req_valid_s = 1'b0;
    if (state_r == REQ) begin
      req_valid_s = !inst_valid_r || !stall;
    end else begin
      req_valid_s = 1'b0;
    end
  end

  // Handshake and mux select; npc_sel must be combinational so the mux
  // can present the redirect target in the same cycle.
  always_comb begin
    hs_s = req_valid_s && imem_req_ready;
    if (redirect_valid) begin
      npc_sel = 2'b01;
    end else begin
      npc_sel = 2'b00;
    end
  end

  // Fetch FSM, PC register, stale-response flag and instruction buffer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= IDLE;
      drop_r       <= 1'b0;
      pc_r         <= RESET_PC;
      inst_valid_r <= 1'b0;
      inst_r       <= 32'h0000_0000;
      inst_pc_r    <= 32'h0000_0000;
    end else begin
      // Decode takes the buffered instruction.
      if (inst_valid_r && !stall) begin
        inst_valid_r <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          state_r <= REQ;
        end
        REQ: begin
          if (hs_s) begin
            state_r <= WAIT;
            // The request just accepted fetches the old path.
            if (redirect_valid) begin
              drop_r <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            state_r <= REQ;
            drop_r  <= 1'b0;
            // A redirect that coincides with the response also kills it.
            if (!drop_r && !redirect_valid) begin
              inst_r       <= imem_rsp_data;
              inst_pc_r    <= pc_r;
              inst_valid_r <= 1'b1;
              pc_r         <= npc;
            end
          end else if (redirect_valid) begin
            drop_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          drop_r  <= 1'b0;
        end
      endcase

      // A redirect overrides everything above: new PC, flush the buffer.
      if (redirect_valid) begin
        pc_r         <= npc;
        inst_valid_r <= 1'b0;
      end
    end
  end

  assign pc             = pc_r;
  assign imem_req_addr  = pc_r;
  assign imem_req_valid = req_valid_s;
  assign inst_valid     = inst_valid_r;
  assign inst           = inst_r;
  assign inst_pc        = inst_pc_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk;
  logic        rstn;
  logic [31:0] npc;
  logic [1:0]  npc_sel;
  logic [31:0] pc;
  logic        redirect_valid;
  logic        stall;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int tests;
  int fails;

  // stimulus variables applied just after each rising edge
  logic        stall_v;
  logic        redir_v;
  logic        ready_v;
  logic [31:0] target_v;

  // simple memory model: one outstanding request, fixed latency
  int          mem_lat;
  int          mem_cnt;
  logic        mem_pend;
  logic [31:0] mem_addr;

  fetch_ctrl #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .npc            (npc),
    .npc_sel        (npc_sel),
    .pc             (pc),
    .redirect_valid (redirect_valid),
    .stall          (stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // next-PC mux model
  assign npc = (npc_sel == 2'b01) ? target_v : pc + 32'd4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // advance one cycle; returns at the falling edge of the new cycle
  task automatic tick();
    @(posedge clk);
    #1;
    stall          = stall_v;
    redirect_valid = redir_v;
    imem_req_ready = ready_v;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0000_0000;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_addr ^ 32'hA5A5_0000;
        mem_pend       = 1'b0;
      end
    end
    @(negedge clk);
    if (rstn && imem_req_valid && imem_req_ready) begin
      mem_pend = 1'b1;
      mem_cnt  = mem_lat;
      mem_addr = imem_req_addr;
    end
  endtask

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] pc;
    logic        iv;
    logic [31:0] ipc;
    logic [31:0] inst;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tests = 0;
    fails = 0;
    tbl[0]  = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h000, 32'h0000_0000};
    tbl[1]  = '{1'b0, 1'b0, 32'h100, 1'b0, 32'h000, 32'h0000_0000};
    tbl[2]  = '{1'b0, 1'b1, 32'h104, 1'b1, 32'h100, 32'hA5A5_0100};
    tbl[3]  = '{1'b0, 1'b0, 32'h104, 1'b0, 32'h100, 32'hA5A5_0100};
    tbl[4]  = '{1'b0, 1'b1, 32'h108, 1'b1, 32'h104, 32'hA5A5_0104};
    tbl[5]  = '{1'b0, 1'b0, 32'h108, 1'b0, 32'h104, 32'hA5A5_0104};
    tbl[6]  = '{1'b1, 1'b0, 32'h10C, 1'b1, 32'h108, 32'hA5A5_0108};
    tbl[7]  = '{1'b1, 1'b0, 32'h10C, 1'b1, 32'h108, 32'hA5A5_0108};
    tbl[8]  = '{1'b1, 1'b0, 32'h10C, 1'b1, 32'h108, 32'hA5A5_0108};
    tbl[9]  = '{1'b0, 1'b1, 32'h10C, 1'b1, 32'h108, 32'hA5A5_0108};
    tbl[10] = '{1'b0, 1'b0, 32'h10C, 1'b0, 32'h108, 32'hA5A5_0108};
    tbl[11] = '{1'b0, 1'b1, 32'h110, 1'b1, 32'h10C, 32'hA5A5_010C};

    stall_v = 1'b0; redir_v = 1'b0; ready_v = 1'b1; target_v = 32'h0;
    stall = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    mem_lat = 1; mem_cnt = 0; mem_pend = 1'b0; mem_addr = 32'h0;
    rstn = 1'b0;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 32'h100);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_npc_sel", {30'd0, npc_sel}, 32'd0);
    rstn = 1'b1;
    #1;
    chk("idle_req_valid", {31'd0, imem_req_valid}, 32'd0);

    // sequential fetch and stall, one row per cycle
    for (int i = 0; i < 12; i++) begin
      stall_v = tbl[i].stall;
      tick();
      chk($sformatf("seq%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, tbl[i].rv});
      chk($sformatf("seq%0d_pc", i), pc, tbl[i].pc);
      chk($sformatf("seq%0d_req_addr", i), imem_req_addr, tbl[i].pc);
      chk($sformatf("seq%0d_inst_valid", i), {31'd0, inst_valid}, {31'd0, tbl[i].iv});
      chk($sformatf("seq%0d_inst_pc", i), inst_pc, tbl[i].ipc);
      chk($sformatf("seq%0d_inst", i), inst, tbl[i].inst);
    end

    // redirect while a slow response is pending
    mem_lat = 3;
    tick();
    tick();
    chk("rw_pre_inst_pc", inst_pc, 32'h110);
    chk("rw_pre_req_addr", imem_req_addr, 32'h114);
    redir_v = 1'b1; target_v = 32'h200;
    tick();
    chk("rw_npc_sel", {30'd0, npc_sel}, 32'd1);
    redir_v = 1'b0;
    tick();
    chk("rw_pc", pc, 32'h200);
    chk("rw_npc_sel_off", {30'd0, npc_sel}, 32'd0);
    chk("rw_wait_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    chk("rw_stale_rsp", {31'd0, imem_rsp_valid}, 32'd1);
    chk("rw_stale_iv", {31'd0, inst_valid}, 32'd0);
    mem_lat = 1;
    tick();
    chk("rw_drop_iv", {31'd0, inst_valid}, 32'd0);
    chk("rw_new_req", {31'd0, imem_req_valid}, 32'd1);
    chk("rw_new_addr", imem_req_addr, 32'h200);
    tick();
    tick();
    chk("rw_tgt_iv", {31'd0, inst_valid}, 32'd1);
    chk("rw_tgt_inst_pc", inst_pc, 32'h200);
    chk("rw_tgt_inst", inst, 32'hA5A5_0200);

    // redirect coincident with the response
    redir_v = 1'b1; target_v = 32'h300;
    tick();
    chk("rc_rsp", {31'd0, imem_rsp_valid}, 32'd1);
    chk("rc_npc_sel", {30'd0, npc_sel}, 32'd1);
    redir_v = 1'b0;
    tick();
    chk("rc_iv", {31'd0, inst_valid}, 32'd0);
    chk("rc_pc", pc, 32'h300);
    chk("rc_npc_sel_off", {30'd0, npc_sel}, 32'd0);
    chk("rc_req_addr", imem_req_addr, 32'h300);
    chk("rc_req_valid", {31'd0, imem_req_valid}, 32'd1);
    mem_lat = 3;
    tick();
    tick();
    chk("rc_tgt_inst_pc", inst_pc, 32'h300);
    chk("rc_tgt_inst", inst, 32'hA5A5_0300);

    // reset pulsed low in WAIT, late response afterwards
    tick();
    chk("rr_wait_req", {31'd0, imem_req_valid}, 32'd0);
    ready_v = 1'b0;
    rstn = 1'b0;
    #1;
    chk("rr_pc", pc, 32'h100);
    chk("rr_inst_pc", inst_pc, 32'h0);
    chk("rr_inst", inst, 32'h0);
    chk("rr_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    rstn = 1'b1;
    mem_lat = 1;
    tick();
    chk("rr_late_rsp", {31'd0, imem_rsp_valid}, 32'd1);
    chk("rr_late_iv", {31'd0, inst_valid}, 32'd0);
    chk("rr_req_valid_after", {31'd0, imem_req_valid}, 32'd1);
    tick();
    chk("rr_late_iv2", {31'd0, inst_valid}, 32'd0);
    chk("rr_late_pc", pc, 32'h100);
    ready_v = 1'b1;
    tick();
    tick();
    tick();
    chk("rr_refetch_iv", {31'd0, inst_valid}, 32'd1);
    chk("rr_refetch_inst_pc", inst_pc, 32'h100);
    chk("rr_refetch_inst", inst, 32'hA5A5_0100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
